// File: rtl/hazard_unit.sv
// hazard_unit: forwarding selects, stall/flush strobes and redirect/freeze
// sequencing for a five-stage pipe, plus stall and redirect counters.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RUN      | normal issue; accepts taken branches and load-use stalls
// REDIRECT | emitting post-branch bubbles, r_cnt bubbles still to go
// FREEZE   | data memory busy; whole pipe held, r_cnt preserved
//
// Forward select encoding: 0 = FW_NONE, 1 = FW_MEM_ALU, 2 = FW_WB_DATA.
module hazard_unit #(
    parameter int REG_ADDR_W   = 5,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] ID_rs1_i,
    input  logic [REG_ADDR_W-1:0] ID_rs2_i,
    input  logic                  ID_use_rs1_i,
    input  logic                  ID_use_rs2_i,
    input  logic [REG_ADDR_W-1:0] EX_rd_i,
    input  logic                  EX_RegWrite_i,
    input  logic                  EX_MemRead_i,
    input  logic [REG_ADDR_W-1:0] MEM_rd_i,
    input  logic                  MEM_RegWrite_i,
    input  logic                  EX_branch_taken_i,
    input  logic                  dmem_busy_i,
    output logic [1:0]            ID_forwardA_o,
    output logic [1:0]            ID_forwardB_o,
    output logic                  pc_stall_o,
    output logic                  IF_ID_stall_o,
    output logic                  IF_ID_flush_o,
    output logic                  ID_EX_flush_o,
    output logic                  pipe_freeze_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
);

    localparam logic [1:0] FW_NONE    = 2'd0;
    localparam logic [1:0] FW_MEM_ALU = 2'd1;
    localparam logic [1:0] FW_WB_DATA = 2'd2;

    localparam logic [1:0] S_RUN      = 2'd0;
    localparam logic [1:0] S_REDIRECT = 2'd1;
    localparam logic [1:0] S_FREEZE   = 2'd2;

    localparam logic [2:0]       C_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_ONE    = 1;

    logic [1:0]       r_state;
    logic [2:0]       r_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic [1:0]       w_state_nxt;
    logic [2:0]       w_cnt_nxt;
    logic             w_ex_fwd_ok;
    logic             w_load_use;
    logic             w_eff_redirect;
    logic             w_flush_accept;

    // A load in EX cannot forward: its data only exists once it reaches MEM.
    function automatic logic [1:0] fw_sel(
        input logic                  use_rs,
        input logic [REG_ADDR_W-1:0] rs,
        input logic                  ex_ok,
        input logic [REG_ADDR_W-1:0] ex_rd,
        input logic                  mem_ok,
        input logic [REG_ADDR_W-1:0] mem_rd
    );
        logic [1:0] sel;
        sel = FW_NONE;
        if (use_rs && (rs != '0)) begin
            if (ex_ok && (ex_rd == rs))
                sel = FW_MEM_ALU;
            else if (mem_ok && (mem_rd == rs))
                sel = FW_WB_DATA;
        end
        return sel;
    endfunction

    assign w_ex_fwd_ok = EX_RegWrite_i && !EX_MemRead_i;
    assign w_load_use  = EX_MemRead_i && (EX_rd_i != '0) &&
                         ((ID_use_rs1_i && (ID_rs1_i == EX_rd_i)) ||
                          (ID_use_rs2_i && (ID_rs2_i == EX_rd_i)));

    // Leaving FREEZE resumes whatever bubble sequence the freeze interrupted.
    assign w_eff_redirect = (r_state == S_REDIRECT) ||
                            ((r_state == S_FREEZE) && (r_cnt != 3'd0));

    // State register, bubble counter and performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_RUN;
            r_cnt       <= 3'd0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (pc_stall_o)
                r_stall_cnt <= r_stall_cnt + C_ONE;
            if (w_flush_accept)
                r_flush_cnt <= r_flush_cnt + C_ONE;
        end
    end

    // Next-state selection: busy dominates, then bubbles, then new redirects.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (dmem_busy_i) begin
            w_state_nxt = S_FREEZE;
        end else if (w_eff_redirect) begin
            w_cnt_nxt   = (r_cnt != 3'd0) ? r_cnt - 3'd1 : 3'd0;
            w_state_nxt = (r_cnt <= 3'd1) ? S_RUN : S_REDIRECT;
        end else if (EX_branch_taken_i) begin
            if (FLUSH_CYCLES > 1) begin
                w_state_nxt = S_REDIRECT;
                w_cnt_nxt   = C_RELOAD;
            end else begin
                w_state_nxt = S_RUN;
                w_cnt_nxt   = 3'd0;
            end
        end else begin
            w_state_nxt = S_RUN;
        end
    end

    // Strobe and forwarding outputs; everything is quiet while in reset.
    always_comb begin
        ID_forwardA_o  = FW_NONE;
        ID_forwardB_o  = FW_NONE;
        pc_stall_o     = 1'b0;
        IF_ID_stall_o  = 1'b0;
        IF_ID_flush_o  = 1'b0;
        ID_EX_flush_o  = 1'b0;
        pipe_freeze_o  = 1'b0;
        w_flush_accept = 1'b0;
        if (!rst) begin
            ID_forwardA_o = fw_sel(ID_use_rs1_i, ID_rs1_i, w_ex_fwd_ok, EX_rd_i,
                                   MEM_RegWrite_i, MEM_rd_i);
            ID_forwardB_o = fw_sel(ID_use_rs2_i, ID_rs2_i, w_ex_fwd_ok, EX_rd_i,
                                   MEM_RegWrite_i, MEM_rd_i);
            if (dmem_busy_i) begin
                pipe_freeze_o = 1'b1;
                pc_stall_o    = 1'b1;
                IF_ID_stall_o = 1'b1;
            end else if (w_eff_redirect) begin
                IF_ID_flush_o = 1'b1;
                ID_EX_flush_o = 1'b1;
            end else if (EX_branch_taken_i) begin
                IF_ID_flush_o  = 1'b1;
                ID_EX_flush_o  = 1'b1;
                w_flush_accept = 1'b1;
            end else if (w_load_use) begin
                pc_stall_o    = 1'b1;
                IF_ID_stall_o = 1'b1;
                ID_EX_flush_o = 1'b1;
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: a FLUSH_CYCLES=2 instance checked against a vector
// table through a scoreboard queue, and a FLUSH_CYCLES=3 instance used for
// the asynchronous-reset-during-redirect case.
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] rs1 = '0, rs2 = '0, exrd = '0, memrd = '0;
    logic       u1 = 0, u2 = 0, exw = 0, exr = 0, memw = 0, br = 0, busy = 0;

    logic [1:0]  fa2, fb2, fa3, fb3;
    logic        ps2, is2, if2, ef2, fz2, ps3, is3, if3, ef3, fz3;
    logic [31:0] sc2, fc2, sc3, fc3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_unit #(.REG_ADDR_W(5), .FLUSH_CYCLES(2), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst),
        .ID_rs1_i(rs1), .ID_rs2_i(rs2), .ID_use_rs1_i(u1), .ID_use_rs2_i(u2),
        .EX_rd_i(exrd), .EX_RegWrite_i(exw), .EX_MemRead_i(exr),
        .MEM_rd_i(memrd), .MEM_RegWrite_i(memw),
        .EX_branch_taken_i(br), .dmem_busy_i(busy),
        .ID_forwardA_o(fa2), .ID_forwardB_o(fb2),
        .pc_stall_o(ps2), .IF_ID_stall_o(is2), .IF_ID_flush_o(if2),
        .ID_EX_flush_o(ef2), .pipe_freeze_o(fz2),
        .stall_cnt_o(sc2), .flush_cnt_o(fc2)
    );

    hazard_unit #(.REG_ADDR_W(5), .FLUSH_CYCLES(3), .CNT_W(32)) u_dut3 (
        .clk(clk), .rst(rst),
        .ID_rs1_i(rs1), .ID_rs2_i(rs2), .ID_use_rs1_i(u1), .ID_use_rs2_i(u2),
        .EX_rd_i(exrd), .EX_RegWrite_i(exw), .EX_MemRead_i(exr),
        .MEM_rd_i(memrd), .MEM_RegWrite_i(memw),
        .EX_branch_taken_i(br), .dmem_busy_i(busy),
        .ID_forwardA_o(fa3), .ID_forwardB_o(fb3),
        .pc_stall_o(ps3), .IF_ID_stall_o(is3), .IF_ID_flush_o(if3),
        .ID_EX_flush_o(ef3), .pipe_freeze_o(fz3),
        .stall_cnt_o(sc3), .flush_cnt_o(fc3)
    );

    // strobe order: {pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_flush, pipe_freeze}
    wire [4:0] str2 = {ps2, is2, if2, ef2, fz2};
    wire [4:0] str3 = {ps3, is3, if3, ef3, fz3};

    typedef struct {
        string      name;
        logic [4:0] rs1, rs2, exrd, memrd;
        logic       u1, u2, exw, exr, memw, br, busy;
        logic [1:0] fa, fb;
        logic [4:0] st;
        int         sc, fc;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    function automatic vec_t mk(string nm,
                                logic [4:0] a_rs1, logic a_u1, logic [4:0] a_rs2, logic a_u2,
                                logic [4:0] a_exrd, logic a_exw, logic a_exr,
                                logic [4:0] a_memrd, logic a_memw, logic a_br, logic a_busy,
                                logic [1:0] e_fa, logic [1:0] e_fb, logic [4:0] e_st,
                                int e_sc, int e_fc);
        vec_t v;
        v.name = nm;
        v.rs1 = a_rs1; v.u1 = a_u1; v.rs2 = a_rs2; v.u2 = a_u2;
        v.exrd = a_exrd; v.exw = a_exw; v.exr = a_exr;
        v.memrd = a_memrd; v.memw = a_memw; v.br = a_br; v.busy = a_busy;
        v.fa = e_fa; v.fb = e_fb; v.st = e_st; v.sc = e_sc; v.fc = e_fc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectations, compare at negedge.
    task automatic run_vec(input vec_t v);
        vec_t e;
        rs1 = v.rs1; u1 = v.u1; rs2 = v.rs2; u2 = v.u2;
        exrd = v.exrd; exw = v.exw; exr = v.exr;
        memrd = v.memrd; memw = v.memw; br = v.br; busy = v.busy;
        sb.push_back(v);
        @(negedge clk);
        e = sb.pop_front();
        chk({e.name, ".fwdA"}, 32'(fa2), 32'(e.fa));
        chk({e.name, ".fwdB"}, 32'(fb2), 32'(e.fb));
        chk({e.name, ".strobes"}, 32'(str2), 32'(e.st));
        chk({e.name, ".stall_cnt"}, sc2, 32'(e.sc));
        chk({e.name, ".flush_cnt"}, fc2, 32'(e.fc));
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset with hazards present: everything quiet
        rst = 1; br = 1; busy = 1; rs1 = 5; u1 = 1; exrd = 5; exw = 1;
        #2;
        chk("rst.strobes", 32'(str2), 32'd0);
        chk("rst.fwdA", 32'(fa2), 32'd0);
        chk("rst.fwdB", 32'(fb2), 32'd0);
        chk("rst.stall_cnt", sc2, 32'd0);
        chk("rst.flush_cnt", fc2, 32'd0);
        chk("rst.strobes3", 32'(str3), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 0; br = 0; busy = 0; rs1 = 0; u1 = 0; exrd = 0; exw = 0;

        //                 name       rs1 u1 rs2 u2 exrd w r memrd mw br bz  fa fb  strobes      sc fc
        tbl.push_back(mk("idle",       0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 5'b00000, 0, 0));
        tbl.push_back(mk("fw_ex",      5, 1, 5, 1,  5, 1, 0,  5, 1, 0, 0, 1, 1, 5'b00000, 0, 0));
        tbl.push_back(mk("fw_mem",     5, 1, 5, 1,  6, 1, 0,  5, 1, 0, 0, 2, 2, 5'b00000, 0, 0));
        tbl.push_back(mk("fw_x0",      0, 1, 5, 1,  0, 1, 0,  5, 1, 0, 0, 0, 2, 5'b00000, 0, 0));
        tbl.push_back(mk("fw_nouse",   5, 0, 5, 0,  5, 1, 0,  5, 1, 0, 0, 0, 0, 5'b00000, 0, 0));
        tbl.push_back(mk("lu",         3, 1, 7, 1,  7, 1, 1,  0, 0, 0, 0, 0, 0, 5'b11010, 0, 0));
        tbl.push_back(mk("lu_replay",  0, 0, 7, 1,  0, 0, 0,  7, 1, 0, 0, 0, 2, 5'b00000, 1, 0));
        tbl.push_back(mk("lu_x0",      0, 1, 0, 0,  0, 1, 1,  0, 0, 0, 0, 0, 0, 5'b00000, 1, 0));
        tbl.push_back(mk("lu_nouse",   9, 0, 9, 0,  9, 1, 1,  0, 0, 0, 0, 0, 0, 5'b00000, 1, 0));
        tbl.push_back(mk("br_lu",      7, 1, 0, 0,  7, 1, 1,  0, 0, 1, 0, 0, 0, 5'b00110, 1, 0));
        tbl.push_back(mk("br_bubble",  0, 0, 0, 0,  0, 0, 0,  0, 0, 1, 0, 0, 0, 5'b00110, 1, 1));
        tbl.push_back(mk("br_done",    0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 5'b00000, 1, 1));
        foreach (tbl[i]) run_vec(tbl[i]);

        // freeze with a pending branch, then accept it on release
        run_vec(mk("frz1",         5, 1, 0, 0,  5, 1, 0,  0, 0, 1, 1, 1, 0, 5'b11001, 1, 1));
        run_vec(mk("frz2",         5, 1, 0, 0,  5, 1, 0,  0, 0, 1, 1, 1, 0, 5'b11001, 2, 1));
        run_vec(mk("frz3",         5, 1, 0, 0,  5, 1, 0,  0, 0, 1, 1, 1, 0, 5'b11001, 3, 1));
        run_vec(mk("frz_rel",      0, 0, 0, 0,  0, 0, 0,  0, 0, 1, 0, 0, 0, 5'b00110, 4, 1));
        run_vec(mk("frz_bubble",   0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 5'b00110, 4, 2));
        run_vec(mk("frz_done",     0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 5'b00000, 4, 2));

        // freeze in the middle of a redirect resumes the remaining bubble
        run_vec(mk("rd_br",        0, 0, 0, 0,  0, 0, 0,  0, 0, 1, 0, 0, 0, 5'b00110, 4, 2));
        run_vec(mk("rd_frz",       0, 0, 0, 0,  0, 0, 0,  0, 0, 1, 1, 0, 0, 5'b11001, 4, 3));
        run_vec(mk("rd_resume",    0, 0, 0, 0,  0, 0, 0,  0, 0, 1, 0, 0, 0, 5'b00110, 5, 3));
        run_vec(mk("rd_done",      0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 5'b00000, 5, 3));

        // busy beats load-use; the stall is taken once busy drops
        run_vec(mk("lu_busy",      7, 1, 0, 0,  7, 1, 1,  0, 0, 0, 1, 0, 0, 5'b11001, 5, 3));
        run_vec(mk("lu_after",     7, 1, 0, 0,  7, 1, 1,  0, 0, 0, 0, 0, 0, 5'b11010, 6, 3));
        for (int k = 0; k < 4; k++)
            run_vec(mk("settle",   0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 5'b00000, 7, 3));

        // FLUSH_CYCLES=3 instance: async reset after the first bubble
        br = 1;
        @(negedge clk);
        chk("ar.accept3", 32'(str3), 32'b00110);
        @(posedge clk);
        #1;
        br = 0;
        @(negedge clk);
        chk("ar.bubble3", 32'(str3), 32'b00110);
        #1 rst = 1;
        #1;
        chk("ar.in_rst3", 32'(str3), 32'd0);
        chk("ar.in_rst2", 32'(str2), 32'd0);
        chk("ar.flush_cnt3", fc3, 32'd0);
        chk("ar.stall_cnt2", sc2, 32'd0);
        chk("ar.flush_cnt2", fc2, 32'd0);
        #1 rst = 0;
        @(negedge clk);
        chk("ar.after1_3", 32'(str3), 32'd0);
        chk("ar.after1_2", 32'(str2), 32'd0);
        @(negedge clk);
        chk("ar.after2_3", 32'(str3), 32'd0);
        chk("ar.after_fc3", fc3, 32'd0);

        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
